// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte clients
// Messages are kept whole: the grant is held from first byte to last, or until a timeout revokes it.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int HOLD_TIMEOUT = 1024,
   parameter int TX_TIMEOUT   = 125000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            ack,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          tx_start,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_busy,
   input  logic                          tx_done,
   output logic                          err_timeout
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = IW + 1;
   localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
   localparam int TW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_SEND = 2'd1,
      ARB_WAIT = 2'd2,
      ARB_NEXT = 2'd3
   } arb_state_e;

   arb_state_e              state_q, state_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [IW-1:0]           gidx_q, gidx_d;
   logic [IW-1:0]           ptr_q, ptr_d;
   logic                    last_q, last_d;
   logic [NUM_REQ-1:0]      ack_q, ack_d;
   logic                    tx_start_q, tx_start_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    err_q, err_d;
   logic [HW-1:0]           hold_q, hold_d;
   logic [TW-1:0]           txcnt_q, txcnt_d;

   logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];
   logic [CW-1:0]           cand;
   logic [IW-1:0]           win_idx;
   logic                    win_found;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Search starts one past the last served client, so the most recent owner is tried last.
   always_comb begin
      cand      = '0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + CW'(k);
         if (cand >= CW'(NUM_REQ)) begin
            cand = cand - CW'(NUM_REQ);
         end
         if (!win_found && req[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gidx_d     = gidx_q;
      ptr_d      = ptr_q;
      last_d     = last_q;
      ack_d      = '0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      err_d      = err_q;
      hold_d     = hold_q;
      txcnt_d    = txcnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (win_found) begin
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               gidx_d           = win_idx;
               hold_d           = '0;
               state_d          = ARB_SEND;
            end
         end
         ARB_SEND: begin
            if (!req[gidx_q]) begin
               grant_d = '0;
               state_d = ARB_IDLE;
            end else if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = req_bytes[gidx_q];
               ack_d      = grant_q;
               last_d     = req_last[gidx_q];
               txcnt_d    = '0;
               state_d    = ARB_WAIT;
            end
         end
         ARB_WAIT: begin
            // tx_start_q marks the first WAIT cycle, where a stale tx_done must not count.
            if (tx_done && !tx_start_q) begin
               if (last_q) begin
                  grant_d = '0;
                  ptr_d   = gidx_q;
                  state_d = ARB_IDLE;
               end else begin
                  hold_d  = '0;
                  state_d = ARB_NEXT;
               end
            end else if (txcnt_q == TW'(TX_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               grant_d = '0;
               ptr_d   = gidx_q;
               state_d = ARB_IDLE;
            end else begin
               txcnt_d = txcnt_q + 1'b1;
            end
         end
         ARB_NEXT: begin
            if (req[gidx_q]) begin
               hold_d  = '0;
               state_d = ARB_SEND;
            end else if (hold_q == HW'(HOLD_TIMEOUT - 1)) begin
               grant_d = '0;
               ptr_d   = gidx_q;
               state_d = ARB_IDLE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         ptr_q      <= IW'(NUM_REQ - 1);
         last_q     <= 1'b0;
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         err_q      <= 1'b0;
         hold_q     <= '0;
         txcnt_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gidx_q     <= gidx_d;
         ptr_q      <= ptr_d;
         last_q     <= last_d;
         ack_q      <= ack_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         err_q      <= err_d;
         hold_q     <= hold_d;
         txcnt_q    <= txcnt_d;
      end
   end

   assign ack         = ack_q;
   assign grant       = grant_q;
   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a message-level reference model
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int HT = 8;
   localparam int TT = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req, req_last, ack, grant;
   logic [N*DW-1:0] req_data;
   logic            tx_start;
   logic [DW-1:0]   tx_data;
   logic            tx_busy;
   logic            tx_done = 1'b0;
   logic            err_timeout;

   logic            auto_mode  = 1'b0;
   logic            tx_auto    = 1'b1;
   logic            busy_force = 1'b0;
   logic            busy_m     = 1'b0;
   int              tx_fix     = 0;
   int              tx_left    = 0;
   logic [N-1:0]    req_dir = '0, last_dir = '0, req_auto = '0, last_auto = '0;
   logic [N*DW-1:0] data_dir = '0, data_auto = '0;

   logic [8:0]      cq [N][$];
   logic [11:0]     sb [$];
   int              n_vec = 0;
   int              n_err = 0;
   int              m_ptr = N - 1;
   logic [11:0]     mon_e;
   logic [N-1:0]    mon_oh;

   assign req      = auto_mode ? req_auto  : req_dir;
   assign req_last = auto_mode ? last_auto : last_dir;
   assign req_data = auto_mode ? data_auto : data_dir;
   assign tx_busy  = busy_m | busy_force;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .HOLD_TIMEOUT(HT), .TX_TIMEOUT(TT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
      .ack(ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
      .tx_busy(tx_busy), .tx_done(tx_done), .err_timeout(err_timeout)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input int c);
      int n = 0;
      while (!ack[c] && n < 200) begin
         step();
         n++;
      end
      chk($sformatf("ack_wait_%0d", c), 64'(ack[c]), 64'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (grant != '0 && n < 200) begin
         step();
         n++;
      end
      chk("idle_wait", 64'(grant), 64'd0);
   endtask

   task automatic dir_byte(input int c, input logic [7:0] b, input logic l);
      req_dir[c]           = 1'b1;
      data_dir[c*DW +: DW] = b;
      last_dir[c]          = l;
      sb.push_back({4'(c), b});
   endtask

   task automatic load_msg(input int c, input int len);
      for (int j = 0; j < len; j++) begin
         cq[c].push_back({(j == len - 1), 8'($urandom)});
      end
   endtask

   function automatic int cq_total();
      int t = 0;
      for (int i = 0; i < N; i++) t += cq[i].size();
      return t;
   endfunction

   // Whole messages are served in round-robin order from the client after the last owner.
   task automatic run_auto();
      logic [8:0] mq [N][$];
      logic [8:0] x;
      int found;
      int n = 0;
      for (int i = 0; i < N; i++) mq[i] = cq[i];
      forever begin
         found = -1;
         for (int k = 1; k <= N; k++) begin
            if (found < 0 && mq[(m_ptr + k) % N].size() > 0) found = (m_ptr + k) % N;
         end
         if (found < 0) break;
         do begin
            x = mq[found].pop_front();
            sb.push_back({4'(found), x[7:0]});
         end while (!x[8]);
         m_ptr = found;
      end
      auto_mode = 1'b1;
      while (n < 4000 && !(sb.size() == 0 && cq_total() == 0 && grant == '0)) begin
         step();
         n++;
      end
      chk("drain_sb", 64'(sb.size()), 64'd0);
      chk("drain_clients", 64'(cq_total()), 64'd0);
      auto_mode = 1'b0;
   endtask

   // Clients and transmitter model, updated away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (auto_mode && ack[i] && cq[i].size() > 0) void'(cq[i].pop_front());
            if (cq[i].size() > 0) begin
               req_auto[i]           = 1'b1;
               data_auto[i*DW +: DW] = cq[i][0][7:0];
               last_auto[i]          = cq[i][0][8];
            end else begin
               req_auto[i]  = 1'b0;
               last_auto[i] = 1'b0;
            end
         end
         if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) begin
               tx_done = 1'b1;
               busy_m  = 1'b0;
            end
         end
         if (rst) begin
            tx_left = 0;
            busy_m  = 1'b0;
         end else if (tx_start && tx_auto) begin
            tx_left = (tx_fix > 0) ? tx_fix : int'($urandom_range(15, 1));
            busy_m  = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (tx_start) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_tx_start: got data %0h expected no transfer", tx_data);
               end else begin
                  mon_e  = sb.pop_front();
                  mon_oh = '0;
                  mon_oh[mon_e[9:8]] = 1'b1;
                  chk("tx_data", 64'(tx_data), 64'(mon_e[7:0]));
                  chk("ack", 64'(ack), 64'(mon_oh));
                  chk("grant", 64'(grant), 64'(mon_oh));
               end
            end else if (ack != '0) begin
               chk("ack_without_start", 64'(ack), 64'd0);
            end
            if ((grant & (grant - 1'b1)) != '0) chk("grant_onehot", 64'(grant), 64'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_tx_start", 64'(tx_start), 64'd0);
      chk("rst_tx_data", 64'(tx_data), 64'd0);
      chk("rst_err", 64'(err_timeout), 64'd0);
      rst = 1'b0;

      // single byte latency
      tx_fix = 4;
      dir_byte(2, 8'hA5, 1'b1);
      step();
      chk("t1_grant", 64'(grant), 64'b0100);
      chk("t1_no_start", 64'(tx_start), 64'd0);
      step();
      chk("t1_start", 64'(tx_start), 64'd1);
      req_dir[2] = 1'b0;
      step();
      chk("t1_start_pulse", 64'(tx_start), 64'd0);
      chk("t1_ack_pulse", 64'(ack), 64'd0);
      repeat (3) step();
      chk("t1_grant_held", 64'(grant), 64'b0100);
      step();
      chk("t1_grant_drop", 64'(grant), 64'd0);
      m_ptr = 2;

      // message lock with competing clients
      tx_fix = 10;
      cq[1].push_back({1'b0, 8'h11});
      cq[1].push_back({1'b0, 8'h22});
      cq[1].push_back({1'b1, 8'h33});
      cq[3].push_back({1'b1, 8'h44});
      cq[0].push_back({1'b1, 8'h55});
      cq[2].push_back({1'b1, 8'h66});
      run_auto();

      // tx_done on the terminal count cycle wins over the timeout
      tx_fix = 15;
      dir_byte(0, 8'h3C, 1'b1);
      wait_ack(0);
      req_dir[0] = 1'b0;
      repeat (15) step();
      chk("sim_grant_held", 64'(grant), 64'b0001);
      step();
      chk("sim_grant_drop", 64'(grant), 64'd0);
      chk("sim_no_err", 64'(err_timeout), 64'd0);
      m_ptr = 0;

      // hold timeout
      tx_fix = 3;
      dir_byte(0, 8'h5A, 1'b0);
      wait_ack(0);
      req_dir[0] = 1'b0;
      dir_byte(1, 8'hC3, 1'b1);
      repeat (11) step();
      chk("hold_grant_held", 64'(grant), 64'b0001);
      step();
      chk("hold_revoke", 64'(grant), 64'd0);
      step();
      chk("hold_next_grant", 64'(grant), 64'b0010);
      wait_ack(1);
      req_dir[1] = 1'b0;
      wait_idle();
      m_ptr = 1;

      // transmitter timeout
      tx_auto = 1'b0;
      dir_byte(2, 8'h96, 1'b1);
      wait_ack(2);
      req_dir[2] = 1'b0;
      repeat (15) step();
      chk("tto_grant_held", 64'(grant), 64'b0100);
      chk("tto_err_clear", 64'(err_timeout), 64'd0);
      step();
      chk("tto_grant_drop", 64'(grant), 64'd0);
      chk("tto_err_set", 64'(err_timeout), 64'd1);
      tx_auto = 1'b1;
      tx_fix  = 5;
      dir_byte(3, 8'h69, 1'b1);
      wait_ack(3);
      req_dir[3] = 1'b0;
      wait_idle();
      chk("tto_err_sticky", 64'(err_timeout), 64'd1);
      m_ptr = 3;

      // busy stall then reset during WAIT
      tx_auto    = 1'b0;
      busy_force = 1'b1;
      dir_byte(0, 8'hE7, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("busy_no_start", 64'(tx_start), 64'd0);
      end
      busy_force = 1'b0;
      step();
      chk("busy_release_start", 64'(tx_start), 64'd1);
      req_dir[0] = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      chk("mid_rst_grant", 64'(grant), 64'd0);
      chk("mid_rst_ack", 64'(ack), 64'd0);
      chk("mid_rst_start", 64'(tx_start), 64'd0);
      chk("mid_rst_err", 64'(err_timeout), 64'd0);
      rst     = 1'b0;
      m_ptr   = N - 1;
      tx_auto = 1'b1;
      tx_fix  = 0;

      // after reset client 0 wins first
      for (int c = 0; c < N; c++) load_msg(c, 1);
      run_auto();

      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < N; c++) begin
            int nm = int'($urandom_range(3, 0));
            for (int m = 0; m < nm; m++) load_msg(c, int'($urandom_range(3, 1)));
         end
         run_auto();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among NUM_REQ byte-producing clients.
- Each client presents a byte with a request; the arbiter grants one client, issues a single-cycle start to the transmitter and returns a one-cycle acknowledge.
- It waits for the transmitter's completion pulse before serving the next byte.
- It supports multi-byte messages via a per-client last flag, so a message is never interleaved with another client's bytes.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
DATA_WIDTH, 8, byte width carried to transmitter
HOLD_TIMEOUT, 1024, clock cycles a granted client may idle mid-message before grant is revoked
TX_TIMEOUT, 125000, clock cycles allowed from tx_start to tx_done before abort (about 12 bit times at 100 MHz/9600)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req  input  NUM_REQ  per-client request; held high with stable data until ack
req_data  input  NUM_REQ*DATA_WIDTH  packed bytes, client i at [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  per-client: current byte ends the message
ack  output  NUM_REQ  one-cycle pulse: client's byte accepted
grant  output  NUM_REQ  one-hot current owner; 0 when idle
tx_start  output  1  one-cycle start pulse to UART transmitter
tx_data  output  DATA_WIDTH  byte to transmitter, valid from tx_start until next tx_start
tx_busy  input  1  transmitter busy, level
tx_done  input  1  transmitter one-cycle pulse at end of stop bit
err_timeout  output  1  sticky: a TX_TIMEOUT abort occurred

Behaviour:
- All outputs are registered. Reset values: ack=0, grant=0, tx_start=0, tx_data=0, err_timeout=0, state=ARB_IDLE, rr pointer=NUM_REQ-1, counters=0.
- Reset is synchronous to clk and has priority over all other events. Reset mid-transfer drops grant and state immediately; the transmitter is not told.
- Round-robin: search begins at pointer+1 modulo NUM_REQ; the first asserted req wins. The pointer updates to the winner's index only when its message ends or is revoked. After reset, client 0 has highest priority.
- States:
  - ARB_IDLE: if any req, set grant one-hot to the winner, clear hold counter, go to ARB_SEND. Otherwise stay.
  - ARB_SEND: if req[g]=0 (protocol violation), grant<=0, go to ARB_IDLE, pointer unchanged. Else if tx_busy=0, on that edge set tx_start<=1, tx_data<=req_data[g], ack[g]<=1, latch last<=req_last[g], clear tx counter, go to ARB_WAIT. Else (tx_busy=1) stay.
  - ARB_WAIT: tx_start and ack are high only in the first cycle. tx_done is ignored in that first cycle.
    - On tx_done with last=1: grant<=0, pointer<=g, go to ARB_IDLE.
    - On tx_done with last=0: go to ARB_NEXT.
    - If the tx counter reaches TX_TIMEOUT-1 without tx_done: err_timeout<=1, grant<=0, pointer<=g, go to ARB_IDLE.
  - ARB_NEXT: grant is held and other requesters are blocked.
    - If req[g]=1: go to ARB_SEND and clear the hold counter.
    - Else increment the hold counter. At HOLD_TIMEOUT-1: grant<=0, pointer<=g, go to ARB_IDLE.
- Latency: req rises with the arbiter idle and tx_busy=0. grant is visible 1 cycle later; tx_start and ack are visible 2 cycles later.
- Back-to-back: after tx_done of a last byte, the next grant appears 1 cycle later (ARB_IDLE evaluation cycle).
- Simultaneous tx_done and timeout terminal count: tx_done wins and err_timeout is not set.
- A client whose req drops and rises in the same cycle it is acked is treated as a new byte.
- Unused state encodings go to ARB_IDLE.
- Counter widths are sized with $clog2 of their timeout; no wrap is possible because each counter is cleared on state entry.
- err_timeout clears only on rst.

Test Plan:
1. Single byte: NUM_REQ=4, req[2]=1, req_data[2]=8'hA5, req_last[2]=1, tx_busy=0 -> grant=4'b0100 at +1; tx_start=1, tx_data=A5, ack=4'b0100 at +2 for one cycle. After tx_done, grant=0 one cycle later.
2. Round-robin fairness: req=4'b1111 held, all last=1, tx_done returned 10 cycles after each tx_start -> ack order 0,1,2,3,0; no client served twice before the others.
3. Message lock: client 1 sends 3 bytes 11,22,33 (last only on 33) while req[3]=1 -> tx_data sequence 11,22,33 with grant=4'b0010 throughout; client 3 is served immediately after.
4. Hold timeout: HOLD_TIMEOUT=8, client 0 sends a non-last byte then drops req -> grant=0 exactly 8 cycles after entering ARB_NEXT. Next grant goes to client 1 if it is requesting.
5. TX timeout: TX_TIMEOUT=16, tx_done held 0 -> 16 cycles after tx_start, err_timeout=1 and grant=0. A subsequent request still completes; err_timeout stays 1 until rst.
6. Busy stall and reset: tx_busy=1 for 5 cycles with req[0] pending -> no tx_start until tx_busy=0. Assert rst during ARB_WAIT -> next cycle grant=0, ack=0, tx_start=0, err_timeout=0, client 0 highest priority again.
